btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
- Sits directly downstream of the debounce stage; consumes its clean, clk-synchronous button level.
- Classifies each press as short, long or double-click and emits one-cycle event pulses.
- Maintains a wrapping mode index and a play-enable flag, which the top level routes to the light and music generators.

Parameters:
- LONG_CYCLES, 100_000_000: held cycles in PRESS1/PRESS2 that qualify a long press.
- GAP_CYCLES, 30_000_000: maximum released cycles after the first press for a second press to count as a double-click.
- MODE_NUM, 4: number of modes, range 2..2**MODE_W.
- MODE_W, 2: width of mode.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- btn_debounce  input  1  debounced button level, synchronous to clk, 1 = pressed
- short_pulse  output  1  one-cycle strobe: short press confirmed
- long_pulse  output  1  one-cycle strobe: long press confirmed
- double_pulse  output  1  one-cycle strobe: double-click confirmed
- mode  output  MODE_W  current mode index
- play_en  output  1  play/run enable

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, btn_s=0; short_pulse/long_pulse/double_pulse=0; mode=0; play_en=1.
- btn_s is btn_debounce registered once. The FSM acts only on btn_s. No further synchronisation is needed.
- cnt is a 27-bit counter (width >= clog2(max(LONG_CYCLES,GAP_CYCLES))). It clears on every state change and increments once per cycle while in a state. It never wraps: the terminal compare always exits the state first.
- IDLE:
  - btn_s=1 -> PRESS1.
- PRESS1:
  - btn_s=0 -> WAIT_GAP.
  - btn_s=1 and cnt==LONG_CYCLES-1 -> LONG_HOLD; assert long_pulse.
- WAIT_GAP:
  - btn_s=1 -> PRESS2.
  - btn_s=0 and cnt==GAP_CYCLES-1 -> IDLE; assert short_pulse.
- PRESS2:
  - btn_s=0 -> IDLE; assert double_pulse.
  - btn_s=1 and cnt==LONG_CYCLES-1 -> LONG_HOLD; assert long_pulse. No double_pulse; the first press is discarded.
- LONG_HOLD:
  - btn_s=0 -> IDLE.
  - No pulse while held, however long.
- Pulses:
  - Registered; high for exactly one cycle, in the cycle after the deciding transition.
  - At most one pulse per cycle. Pulses are mutually exclusive by construction.
- mode:
  - Updates in the same cycle its pulse is high.
  - short_pulse: mode+1, wrapping MODE_NUM-1 -> 0.
  - double_pulse: mode-1, wrapping 0 -> MODE_NUM-1.
  - long_pulse: no change to mode.
- play_en:
  - Toggles when long_pulse is high; otherwise holds.
- Latency:
  - Short press: short_pulse arrives GAP_CYCLES+2 cycles after the release edge on btn_debounce (one cycle for the btn_s register, GAP_CYCLES in WAIT_GAP, one for the registered pulse). This trades latency for double-click detection.
  - Long press: long_pulse arrives LONG_CYCLES+2 cycles after the press edge on btn_debounce.
- Boundaries:
  - A release on the same cycle cnt hits LONG_CYCLES-1 counts as a release (short path). The release check has priority.
  - A press on the same cycle cnt hits GAP_CYCLES-1 goes to PRESS2. The press check has priority.
  - A third press after a double-click starts a fresh sequence from IDLE.
  - rst asserted mid-sequence: immediate return to reset values. No pulse is emitted for the partial sequence.
  - Button held through rst deassertion: FSM sees btn_s=1 in IDLE and enters PRESS1. This is treated as a new press.

Test Plan (LONG_CYCLES=20, GAP_CYCLES=10, MODE_NUM=4):
1. Reset, then idle 50 cycles -> all pulses 0, mode=0, play_en=1. Assert rst=0 mid-PRESS1 -> outputs return to reset values within the same cycle, no pulse.
2. Press 5 cycles, release, wait 30 -> exactly one short_pulse 12 cycles after release, mode=1. Repeat 4 times total -> mode sequence 1,2,3,0.
3. Hold 40 cycles -> exactly one long_pulse 22 cycles after press edge, play_en=0, mode unchanged. Second long press -> play_en=1.
4. Press 5, release 4, press 5, release -> one double_pulse, no short_pulse, mode 0 -> 3.
5. Press 5, release 12, press 5, release -> two short_pulses, no double_pulse, mode 0 -> 2.
6. Press 5, release 3, hold 30 -> one long_pulse, no double or short pulse, play_en toggles, mode unchanged.

Source files
------------

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into short / long / double-click strobes,
// and keeps a wrapping mode index plus a play-enable flag driven by them.
module btn_event_decoder #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 30_000_000,
  parameter int MODE_NUM    = 4,
  parameter int MODE_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_debounce,
  output logic              short_pulse,
  output logic              long_pulse,
  output logic              double_pulse,
  output logic [MODE_W-1:0] mode,
  output logic              play_en
);

  localparam int CNT_W = 27;
  localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s <= 1'b0;
    end else begin
      btn_s <= btn_debounce;
    end
  end

  // cnt only runs in the timed states, so it cannot wrap in IDLE or LONG_HOLD;
  // the release/press checks come first so they win on the terminal count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      mode         <= '0;
      play_en      <= 1'b1;
    end else begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      double_pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_s) begin
            state <= PRESS1;
          end
        end
        PRESS1: begin
          if (!btn_s) begin
            state <= WAIT_GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG_HOLD;
            cnt        <= '0;
            long_pulse <= 1'b1;
            play_en    <= ~play_en;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_GAP: begin
          if (btn_s) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            short_pulse <= 1'b1;
            mode        <= (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESS2: begin
          if (!btn_s) begin
            state        <= IDLE;
            cnt          <= '0;
            double_pulse <= 1'b1;
            mode         <= (mode == '0) ? MODE_LAST : mode - MODE_W'(1);
          end else if (cnt == LONG_LAST) begin
            state      <= LONG_HOLD;
            cnt        <= '0;
            long_pulse <= 1'b1;
            play_en    <= ~play_en;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LONG_HOLD: begin
          cnt <= '0;
          if (!btn_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: button sequences described as press lists,
// expected events derived from press/gap durations and compared in order.
module tb_btn_event_decoder;

  localparam int LONG     = 20;
  localparam int GAP      = 10;
  localparam int MODE_NUM = 4;
  localparam int MODE_W   = 2;

  localparam logic [2:0] K_SHORT  = 3'b100;
  localparam logic [2:0] K_LONG   = 3'b010;
  localparam logic [2:0] K_DOUBLE = 3'b001;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              btn_debounce = 1'b0;
  logic              short_pulse;
  logic              long_pulse;
  logic              double_pulse;
  logic [MODE_W-1:0] mode;
  logic              play_en;

  btn_event_decoder #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .MODE_NUM   (MODE_NUM),
    .MODE_W     (MODE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_debounce(btn_debounce),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .mode        (mode),
    .play_en     (play_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]        kind;
    logic [31:0]       cyc;
    logic [MODE_W-1:0] md;
    logic              play;
  } ev_t;

  int  cycle = 0;
  int  total = 0;
  int  bad = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];
  int  press_start[$];
  int  press_len[$];
  int  seq_end;
  int  model_mode = 0;
  bit  model_play = 1'b1;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every cycle a strobe is visible, tagged with the last edge count
  always @(negedge clk) begin
    ev_t ev;
    if (rst && (short_pulse || long_pulse || double_pulse)) begin
      ev.kind = {short_pulse, long_pulse, double_pulse};
      ev.cyc  = 32'(cycle);
      ev.md   = mode;
      ev.play = play_en;
      obs_q.push_back(ev);
    end
  end

  task automatic clear_seq();
    press_start.delete();
    press_len.delete();
    seq_end = 0;
  endtask

  task automatic add_press(input int gap, input int len);
    press_start.push_back(seq_end + gap);
    press_len.push_back(len);
    seq_end = seq_end + gap + len;
  endtask

  function automatic void push_exp(input logic [2:0] kind, input int cyc);
    ev_t ev;
    if (kind == K_SHORT)  model_mode = (model_mode + 1) % MODE_NUM;
    if (kind == K_DOUBLE) model_mode = (model_mode + MODE_NUM - 1) % MODE_NUM;
    if (kind == K_LONG)   model_play = ~model_play;
    ev.kind = kind;
    ev.cyc  = 32'(cyc);
    ev.md   = MODE_W'(model_mode);
    ev.play = model_play;
    exp_q.push_back(ev);
  endfunction

  function automatic bit pressed(input int k);
    for (int i = 0; i < press_start.size(); i++)
      if (k >= press_start[i] && k < press_start[i] + press_len[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Expected events from durations: a press longer than LONG is long, a
  // release longer than GAP confirms a short, otherwise the next press pairs.
  task automatic run_sequence();
    int base, i, s, l, gap, tot;
    base = cycle;
    i = 0;
    while (i < press_start.size()) begin
      s = press_start[i];
      l = press_len[i];
      if (l > LONG) begin
        push_exp(K_LONG, base + s + LONG + 2);
        i++;
      end else begin
        gap = (i + 1 < press_start.size()) ? press_start[i+1] - (s + l) : 1 << 30;
        if (gap > GAP) begin
          push_exp(K_SHORT, base + s + l + GAP + 2);
          i++;
        end else begin
          if (press_len[i+1] > LONG) push_exp(K_LONG, base + press_start[i+1] + LONG + 2);
          else push_exp(K_DOUBLE, base + press_start[i+1] + press_len[i+1] + 2);
          i += 2;
        end
      end
    end
    tot = seq_end + LONG + GAP + 10;
    for (int k = 0; k < tot; k++) begin
      btn_debounce = pressed(k);
      @(posedge clk);
      #1;
    end
    btn_debounce = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_debounce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({short_pulse, long_pulse, double_pulse, mode, play_en} !== {3'b000, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values got=%b want=%b", {short_pulse, long_pulse, double_pulse, mode, play_en}, {3'b000, 2'd0, 1'b1});
    end
    rst = 1'b1;
    obs_q.delete();
    repeat (50) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL idle_pulses got=%0d want=0", obs_q.size());
    end
    total++;
    if ({mode, play_en} !== {2'd0, 1'b1}) begin
      bad++;
      $display("FAIL idle_state got mode=%0d play=%b want mode=0 play=1", mode, play_en);
    end
  endtask

  task automatic test_short();
    obs_q.delete(); exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      clear_seq();
      add_press(2, 5);
      run_sequence();
      total++;
      if (mode !== MODE_W'((r + 1) % 4)) begin
        bad++;
        $display("FAIL short_mode rep%0d got=%0d want=%0d", r, mode, (r + 1) % 4);
      end
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL short_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL short_ev%0d got kind=%b cyc=%0d mode=%0d play=%b want kind=%b cyc=%0d mode=%0d play=%b", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].md, obs_q[i].play, exp_q[i].kind, exp_q[i].cyc, exp_q[i].md, exp_q[i].play);
      end
    end
  endtask

  task automatic test_long();
    obs_q.delete(); exp_q.delete();
    clear_seq();
    add_press(2, 40);
    run_sequence();
    total++;
    if ({mode, play_en} !== {2'd0, 1'b0}) begin
      bad++;
      $display("FAIL long_first got mode=%0d play=%b want mode=0 play=0", mode, play_en);
    end
    clear_seq();
    add_press(2, 40);
    run_sequence();
    total++;
    if ({mode, play_en} !== {2'd0, 1'b1}) begin
      bad++;
      $display("FAIL long_second got mode=%0d play=%b want mode=0 play=1", mode, play_en);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL long_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL long_ev%0d got kind=%b cyc=%0d mode=%0d play=%b want kind=%b cyc=%0d mode=%0d play=%b", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].md, obs_q[i].play, exp_q[i].kind, exp_q[i].cyc, exp_q[i].md, exp_q[i].play);
      end
    end
  endtask

  task automatic test_double();
    obs_q.delete(); exp_q.delete();
    clear_seq();
    add_press(2, 5);
    add_press(4, 5);
    run_sequence();
    total++;
    if (mode !== 2'd3) begin
      bad++;
      $display("FAIL double_mode got=%0d want=3", mode);
    end
    // Gap/short split: 12 released cycles is too long for a double-click
    clear_seq();
    add_press(2, 5);
    add_press(12, 5);
    run_sequence();
    // Second press held past the long threshold discards the first press
    clear_seq();
    add_press(2, 5);
    add_press(3, 30);
    run_sequence();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL double_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL double_ev%0d got kind=%b cyc=%0d mode=%0d play=%b want kind=%b cyc=%0d mode=%0d play=%b", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].md, obs_q[i].play, exp_q[i].kind, exp_q[i].cyc, exp_q[i].md, exp_q[i].play);
      end
    end
  endtask

  task automatic test_boundaries();
    obs_q.delete(); exp_q.delete();
    clear_seq();
    add_press(2, LONG);
    run_sequence();
    clear_seq();
    add_press(2, LONG + 1);
    run_sequence();
    clear_seq();
    add_press(2, 5);
    add_press(GAP, 5);
    run_sequence();
    clear_seq();
    add_press(2, 5);
    add_press(GAP + 1, 5);
    run_sequence();
    clear_seq();
    add_press(2, 3);
    add_press(GAP, LONG);
    run_sequence();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bound_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bound_ev%0d got kind=%b cyc=%0d mode=%0d play=%b want kind=%b cyc=%0d mode=%0d play=%b", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].md, obs_q[i].play, exp_q[i].kind, exp_q[i].cyc, exp_q[i].md, exp_q[i].play);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    clear_seq();
    add_press(2, 4);
    add_press(2, 4);
    add_press(2, 4);
    add_press(1, 6);
    add_press(3, 2);
    add_press(2, 7);
    run_sequence();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_ev%0d got kind=%b cyc=%0d mode=%0d play=%b want kind=%b cyc=%0d mode=%0d play=%b", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].md, obs_q[i].play, exp_q[i].kind, exp_q[i].cyc, exp_q[i].md, exp_q[i].play);
      end
    end
  endtask

  task automatic test_random();
    int n;
    obs_q.delete(); exp_q.delete();
    for (int r = 0; r < 25; r++) begin
      clear_seq();
      n = $urandom_range(1, 4);
      add_press($urandom_range(1, 5), $urandom_range(1, LONG + 6));
      for (int p = 1; p < n; p++)
        add_press($urandom_range(1, GAP + 4), $urandom_range(1, LONG + 6));
      run_sequence();
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_ev%0d got kind=%b cyc=%0d mode=%0d play=%b want kind=%b cyc=%0d mode=%0d play=%b", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].md, obs_q[i].play, exp_q[i].kind, exp_q[i].cyc, exp_q[i].md, exp_q[i].play);
      end
    end
    total++;
    if ({mode, play_en} !== {MODE_W'(model_mode), model_play}) begin
      bad++;
      $display("FAIL rand_final got mode=%0d play=%b want mode=%0d play=%b", mode, play_en, model_mode, model_play);
    end
  endtask

  task automatic test_reset_midseq();
    obs_q.delete(); exp_q.delete();
    // Move mode and play_en away from their reset values first
    clear_seq();
    add_press(2, LONG + 8);
    run_sequence();
    while (model_mode == 0) begin
      clear_seq();
      add_press(2, 5);
      run_sequence();
    end
    btn_debounce = 1'b1;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b0;
    model_mode = 0;
    model_play = 1'b1;
    #1;
    total++;
    if ({short_pulse, long_pulse, double_pulse, mode, play_en} !== {3'b000, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL midreset_values got=%b want=%b", {short_pulse, long_pulse, double_pulse, mode, play_en}, {3'b000, 2'd0, 1'b1});
    end
    btn_debounce = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    // Reset again while a short press waits out its gap
    btn_debounce = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    btn_debounce = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    obs_q.delete(); exp_q.delete();
    repeat (40) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() != 0 || mode !== 2'd0) begin
      bad++;
      $display("FAIL partial_seq got pulses=%0d mode=%0d want pulses=0 mode=0", obs_q.size(), mode);
    end
    // Button held across reset release is a fresh press
    btn_debounce = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_seq();
    add_press(0, 5);
    run_sequence();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL held_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL held_ev%0d got kind=%b cyc=%0d mode=%0d play=%b want kind=%b cyc=%0d mode=%0d play=%b", i, obs_q[i].kind, obs_q[i].cyc, obs_q[i].md, obs_q[i].play, exp_q[i].kind, exp_q[i].cyc, exp_q[i].md, exp_q[i].play);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_reset_midseq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
